// File: rtl/conv_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : conv_rr_arbiter
// Purpose  : Round-robin sharing of one int16->float32 and one float32->int16
//            converter among NUM_REQ requesters, with a one-entry result register.
// Revision : 1.0
// ============================================================================

module int16_to_float32 (
  input  logic [15:0] in_val,
  output logic [31:0] out_val
);
  logic [15:0] mag;
  logic [3:0]  msb;
  logic [22:0] frac;

  always_comb begin
    mag = in_val[15] ? (~in_val + 16'd1) : in_val;
    msb = 4'd0;
    for (int b = 0; b < 16; b++) begin
      if (mag[b]) msb = 4'(b);
    end
    // The implicit leading one is shifted out of the 23-bit fraction field.
    frac    = 23'({mag[14:0], 8'd0} << (4'd15 - msb));
    out_val = (mag == 16'd0) ? 32'd0 : {in_val[15], 8'd127 + {4'd0, msb}, frac};
  end
endmodule

module float32_to_int16 (
  input  logic [31:0] in_val,
  output logic [15:0] out_val
);
  logic [7:0]  expo;
  logic [15:0] mag;

  always_comb begin
    expo = in_val[30:23];
    mag  = 16'(({1'b1, in_val[22:0]}) >> (8'd150 - expo));
    // Truncates toward zero; NaN maps to 0, out-of-range saturates.
    if (expo == 8'hFF && in_val[22:0] != 23'd0) out_val = 16'd0;
    else if (expo < 8'd127)                      out_val = 16'd0;
    else if (expo >= 8'd142)                     out_val = in_val[31] ? 16'h8000 : 16'h7FFF;
    else                                         out_val = in_val[31] ? (~mag + 16'd1) : mag;
  end
endmodule

module conv_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_op,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_op,
  output logic [31:0]           rsp_data
);
  logic [ID_W-1:0] r_ptr;
  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;
  logic            r_rsp_op;
  logic [31:0]     r_rsp_data;

  logic            w_found;
  logic [ID_W-1:0] w_grant;
  logic [ID_W:0]   w_idx;
  logic            w_can_accept;
  logic            w_accept;
  logic            w_sel_op;
  logic [31:0]     w_sel_data;
  logic [31:0]     w_i2f;
  logic [15:0]     w_f2i;
  logic [31:0]     w_result;
  logic [ID_W-1:0] w_ptr_next;

  // Scan from the highest offset down so the nearest valid requester to ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NUM_REQ)) w_idx = w_idx - (ID_W+1)'(NUM_REQ);
      if (req_valid[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_can_accept = !r_rsp_valid || rsp_ready;
  assign w_accept     = w_found && w_can_accept && !rst;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_grant] = 1'b1;
  end

  always_comb begin
    w_sel_op   = 1'b0;
    w_sel_data = 32'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == ID_W'(i)) begin
        w_sel_op   = req_op[i];
        w_sel_data = req_data[32*i +: 32];
      end
    end
  end

  int16_to_float32 u_i2f (.in_val(w_sel_data[15:0]), .out_val(w_i2f));
  float32_to_int16 u_f2i (.in_val(w_sel_data),       .out_val(w_f2i));

  assign w_result   = w_sel_op ? {{16{w_f2i[15]}}, w_f2i} : w_i2f;
  assign w_ptr_next = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_op    <= 1'b0;
      r_rsp_data  <= 32'd0;
    end else if (w_accept) begin
      r_ptr       <= w_ptr_next;
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_grant;
      r_rsp_op    <= w_sel_op;
      r_rsp_data  <= w_result;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_op    = r_rsp_op;
  assign rsp_data  = r_rsp_data;
endmodule

`default_nettype wire

// File: tb/tb_conv_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_rr_arbiter
// Purpose  : Directed self-checking bench for conv_rr_arbiter.
// Revision : 1.0
// ============================================================================
module tb_conv_rr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_op;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_op;
  logic [31:0]           rsp_data;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I2F_IN  [5] = '{32'h0000_0008, 32'h0000_FFFF, 32'h0000_7FFF, 32'h0000_8000, 32'h0000_0000};
  localparam logic [31:0] I2F_EXP [5] = '{32'h4100_0000, 32'hBF80_0000, 32'h46FF_FE00, 32'hC700_0000, 32'h0000_0000};
  localparam logic [31:0] F2I_IN  [4] = '{32'hC300_0000, 32'h3F80_0000, 32'h46FF_FE00, 32'hC700_0000};
  localparam logic [31:0] F2I_EXP [4] = '{32'hFFFF_FF80, 32'h0000_0001, 32'h0000_7FFF, 32'hFFFF_8000};
  // float32 of 1.0, 2.0, 3.0, 4.0
  localparam logic [31:0] RR_EXP  [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};

  conv_rr_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_op(rsp_op),
    .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; req_op = '0; req_data = '0; rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0 || rsp_op !== 1'b0) begin errors++; $display("FAIL reset_id_op: got %0d/%b expected 0/0", rsp_id, rsp_op); end
    checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", rsp_data); end
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_i2f();
    rsp_ready = 1'b1; req_op = 4'b0000;
    for (int v = 0; v < 5; v++) begin
      req_valid = 4'b0001; req_data[31:0] = I2F_IN[v];
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL i2f_ready[%0d]: got %b expected 0001", v, req_ready); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_op !== 1'b0) begin errors++; $display("FAIL i2f_tag[%0d]: got v=%b id=%0d op=%b expected 1/0/0", v, rsp_valid, rsp_id, rsp_op); end
      checks++; if (rsp_data !== I2F_EXP[v]) begin errors++; $display("FAIL i2f_data[%0d]: got %h expected %h", v, rsp_data, I2F_EXP[v]); end
    end
    req_valid = '0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL i2f_drain: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_f2i();
    rsp_ready = 1'b1; req_op = 4'b0100;
    for (int v = 0; v < 4; v++) begin
      req_valid = 4'b0100; req_data[95:64] = F2I_IN[v];
      @(negedge clk);
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL f2i_ready[%0d]: got %b expected 0100", v, req_ready); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_op !== 1'b1) begin errors++; $display("FAIL f2i_tag[%0d]: got v=%b id=%0d op=%b expected 1/2/1", v, rsp_valid, rsp_id, rsp_op); end
      checks++; if (rsp_data !== F2I_EXP[v]) begin errors++; $display("FAIL f2i_data[%0d]: got %h expected %h", v, rsp_data, F2I_EXP[v]); end
    end
    req_valid = '0; req_op = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    int g;
    do_reset();
    rsp_ready = 1'b1; req_op = '0;
    for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = 32'(i + 1);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      g = k % 4;
      exp_rdy = 4'b0001 << g;
      @(negedge clk);
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, exp_rdy); end
      @(posedge clk); #1;
      checks++; if (rsp_id !== 2'(g) || rsp_data !== RR_EXP[g]) begin errors++; $display("FAIL rr_rsp[%0d]: got id=%0d data=%h expected id=%0d data=%h", k, rsp_id, rsp_data, g, RR_EXP[g]); end
    end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    rsp_ready = 1'b1; req_op = '0;
    req_data[63:32] = 32'h0000_0008; req_data[127:96] = 32'h0000_FFFF;
    req_valid = 4'b0010;
    @(posedge clk); #1;
    checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL wrap_first: got id=%0d expected 1", rsp_id); end
    req_valid = 4'b1010;
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ready3: got %b expected 1000", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_id !== 2'd3 || rsp_data !== 32'hBF80_0000) begin errors++; $display("FAIL wrap_rsp3: got id=%0d data=%h expected id=3 data=bf800000", rsp_id, rsp_data); end
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ready1: got %b expected 0010", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_id !== 2'd1 || rsp_data !== 32'h4100_0000) begin errors++; $display("FAIL wrap_rsp1: got id=%0d data=%h expected id=1 data=41000000", rsp_id, rsp_data); end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b1; req_op = '0;
    req_data[31:0] = 32'h0000_0008; req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = 4'b0010; req_data[63:32] = 32'h0000_0002; rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h4100_0000) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d data=%h expected 1/0/41000000", c, rsp_valid, rsp_id, rsp_data); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b expected 0010", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'h4000_0000) begin errors++; $display("FAIL bp_overwrite: got v=%b id=%0d data=%h expected 1/1/40000000", rsp_valid, rsp_id, rsp_data); end
    req_valid = '0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    // ptr is 2 here; granting requester 2 moves it to 3.
    rsp_ready = 1'b0; req_op = '0;
    req_data[95:64] = 32'h0000_0008; req_data[127:96] = 32'h0000_0008;
    req_valid = 4'b0100;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL rm_pre: got v=%b id=%0d expected 1/2", rsp_valid, rsp_id); end
    rst = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin errors++; $display("FAIL rm_cleared: got v=%b data=%h expected 0/00000000", rsp_valid, rsp_data); end
    rst = 1'b0; req_valid = 4'b1100;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rm_ready: got %b expected 0100", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL rm_first: got v=%b id=%0d expected 1/2", rsp_valid, rsp_id); end
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_data = '0; rsp_ready = 1'b0;
    test_reset();
    test_i2f();
    test_f2i();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/conv_rr_arbiter.md
Name: conv_rr_arbiter

Overview:
- Shares one Int16toFloat32 instance and one Float32toInt16 instance between NUM_REQ requesters.
- Each requester issues a conversion with a valid/ready handshake.
- The block grants requesters round-robin, registers the converted result and returns it on a single response channel, tagged with the requester index.
- Sits between the audio/DSP engines and the shared conversion datapath.

Parameters:
- NUM_REQ, 4, number of requesters (minimum 2).
- ID_W, $clog2(NUM_REQ), width of the requester index (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_op  in  NUM_REQ  per-requester op: 0 = int16->float32, 1 = float32->int16.
- req_data  in  NUM_REQ*32  per-requester operand; requester i uses slice [32*i+31:32*i]. For op 0 only bits [15:0] are used.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_op  out  1  op of the result.
- rsp_data  out  32  result. Op 0: float32 bit pattern. Op 1: int16 sign-extended to 32 bits.

Behaviour:
- Handshake rules:
  - A transfer occurs when valid and ready are both high at a posedge.
  - Requesters hold req_valid, req_op and req_data stable until their req_ready is seen high.
  - Same rule for rsp_valid and rsp_data until rsp_ready.
- State:
  - Round-robin pointer ptr (ID_W bits).
  - One-entry output register: rsp_valid, rsp_id, rsp_op, rsp_data.
- Accept condition: can_accept = !rsp_valid || rsp_ready. Full-throughput pass-through when the consumer keeps rsp_ready high.
- Grant:
  - Combinational. g = first i with req_valid[i]=1, scanning ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - req_ready[g] = can_accept. All other req_ready bits = 0.
  - If no req_valid is high, req_ready = 0.
  - req_ready depends only on req_valid, ptr and register state; it never depends on req_op or req_data.
- On accept (a requester transfers):
  - Next cycle: rsp_valid=1, rsp_id=g, rsp_op=req_op[g].
  - rsp_data = sign-extended Float32toInt16 output (op 1) or Int16toFloat32 output (op 0), computed from req_data[g].
  - ptr <= (g+1) mod NUM_REQ; wrap from NUM_REQ-1 to 0.
  - Latency is exactly 1 cycle from request transfer to rsp_valid.
- On response transfer with no new accept: rsp_valid <= 0. rsp_id, rsp_op and rsp_data hold their values (don't-care).
- Simultaneous response drain and new accept in the same cycle: the register is overwritten with the new result; rsp_valid stays 1.
- Backpressure: while rsp_valid=1 and rsp_ready=0, all req_ready=0, ptr holds and the output register holds.
- ptr advances only on accept. Idle cycles and stalled cycles do not move it.
- Reset (also mid-operation): rsp_valid=0, rsp_id=0, rsp_op=0, rsp_data=0, ptr=0, req_ready=0 in the reset cycle. Any pending result is discarded.
- Conversion arithmetic belongs to the two converter instances. This block adds no rounding or saturation; it only sign-extends bit 15 for op 1.

Test Plan:
- Single requester 0, op 0, data 0x00000008, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_id=0, rsp_data=0x41000000. Data 0x0000FFFF (-1) -> 0xBF800000.
- Requester 2, op 1, data 0xC3000000 -> rsp_data=0xFFFFFF80, rsp_op=1. Data 0x3F800000 -> 0x00000001.
- All four requesters valid continuously, rsp_ready=1, from reset -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_id follows the same sequence one cycle later.
- Requesters 1 and 3 valid, ptr=2 (after a grant to 1) -> grant 3 first, then 1 (wrap-around).
- rsp_ready=0 for 3 cycles with requests pending -> req_ready=0 and rsp_data held stable for all 3 cycles. rsp_ready=1 -> drain and next accept in the same cycle.
- rst asserted while rsp_valid=1 -> next cycle rsp_valid=0, ptr=0; the first request after reset is granted to the lowest-index valid requester.
